// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states, widths
// and the lowest-set-bit helper used to walk burst register masks.
package mem_pkg;

    localparam int DATA_W = 16;
    localparam int MASK_W = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_RESP  = 3'd4,
        ST_WR_BEAT  = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [MASK_W-1:0] mask);
        lowest_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port RAM with one write port and a registered read (data appears the
// cycle after the address).
module mem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];
    logic [DATA_W-1:0] rdata_q;

    // Read returns the old contents on a same-address write; the responder
    // never reads and writes in the same cycle.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder slave: single-word reads/writes and mask-driven LM/SM bursts
// that walk consecutive addresses for each set bit of the register mask.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W     = mem_pkg::DATA_W,
    parameter int DEPTH_LOG2 = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_burst,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [2:0]        rsp_idx,
    output logic              rsp_last,
    output logic              wbeat_req,
    output logic [2:0]        wbeat_idx,
    input  logic              wbeat_valid,
    input  logic [DATA_W-1:0] wbeat_data,
    output logic              done,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; a valid side holds its payload stable until then.

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   base_q, base_d;
    logic [DEPTH_LOG2-1:0]   k_q, k_d;
    logic [MASK_W-1:0]       mask_q, mask_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    we_q, we_d;
    logic                    last_beat_q, last_beat_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_last_q, rsp_last_d;
    logic                    wbeat_req_q, wbeat_req_d;
    logic                    done_q, done_d;

    logic                    ram_we;
    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^req_addr[DATA_W-1:DEPTH_LOG2];

    mem_array #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        k_d         = k_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        we_d        = we_q;
        last_beat_d = last_beat_q;
        rsp_rdata_d = rsp_rdata_q;
        ram_we      = 1'b0;
        ram_addr    = base_q + k_q;
        ram_wdata   = wbeat_data;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    base_d = req_addr[DEPTH_LOG2-1:0];
                    we_d   = req_we;
                    mask_d = req_burst ? req_mask : MASK_W'(1);
                    k_d    = '0;
                    idx_d  = '0;
                    if (req_we && !req_burst) begin
                        ram_we    = 1'b1;
                        ram_addr  = req_addr[DEPTH_LOG2-1:0];
                        ram_wdata = req_wdata;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (mask_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d       = lowest_idx(mask_q);
                    // Only one bit left means this beat is the final one.
                    last_beat_d = (mask_q & (mask_q - MASK_W'(1))) == '0;
                    state_d     = we_q ? ST_WR_BEAT : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                rsp_rdata_d = ram_rdata;
                state_d     = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (rsp_ready) begin
                    mask_d  = mask_q & ~(MASK_W'(1) << idx_q);
                    k_d     = k_q + DEPTH_LOG2'(1);
                    state_d = last_beat_q ? ST_DONE : ST_SCAN;
                end
            end
            ST_WR_BEAT: begin
                if (wbeat_valid) begin
                    ram_we  = 1'b1;
                    mask_d  = mask_q & ~(MASK_W'(1) << idx_q);
                    k_d     = k_q + DEPTH_LOG2'(1);
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = (state_d == ST_RD_RESP);
        rsp_last_d  = (state_d == ST_RD_RESP) && last_beat_d;
        wbeat_req_d = (state_d == ST_WR_BEAT);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            k_q         <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            last_beat_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            wbeat_req_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            k_q         <= k_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            last_beat_q <= last_beat_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            wbeat_req_q <= wbeat_req_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_idx   = idx_q;
    assign rsp_last  = rsp_last_q;
    assign wbeat_req = wbeat_req_q;
    assign wbeat_idx = idx_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
